// File: rtl/dff_pipe.sv
// dff_pipe: elastic pipeline register, DEPTH stages of WIDTH bits, each stage
// with its own valid bit. Valid/ready on both ends. An empty stage accepts a
// word even while the stages after it are stalled, so bubbles collapse.
// Optional feature: define DFF_PIPE_OCC_EN to add the registered held-word
// count output occ.
module dff_pipe #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             c,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    input  logic             flush
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH:0]   rdy;

    // Ready ripples back from the sink: a stage can take a word if it is
    // empty or if its own word moves on this edge.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = q_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] | rdy[i+1];
        end
    end

    // Flush blocks input so a word offered alongside it is never taken.
    assign d_ready = rdy[0] & !flush;
    assign q       = data[DEPTH-1];
    assign q_valid = v[DEPTH-1];

    // Stage advance: every ready stage loads its predecessor's valid bit, and
    // its data only when that predecessor held a word; flush clears the valid
    // bits while data keeps its last value.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= INIT;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= d_valid;
                if (d_valid) begin
                    data[0] <= d;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        data[i] <= data[i-1];
                    end
                end
            end
        end
    end

`ifdef DFF_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = d_valid & d_ready;
    assign out_xfer = v[DEPTH-1] & q_ready & !flush;

    // Held-word count tracks the valid bits: up on input only, down on output only.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ <= occ - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed bench for dff_pipe. One instance at DEPTH=4 with
// INIT=8'hA5 and a second at DEPTH=1 with INIT=8'h3C, sharing clock and reset.
// occ is connected and checked only when DFF_PIPE_OCC_EN is defined.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       r   = 1'b0;

    logic [7:0] d = '0;
    logic       d_valid = 1'b0;
    logic       d_ready;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ready = 1'b0;
    logic       flush = 1'b0;

    logic [7:0] d1 = '0;
    logic       d_valid1 = 1'b0;
    logic       d_ready1;
    logic [7:0] q1;
    logic       q_valid1;
    logic       q_ready1 = 1'b0;
    logic       flush1 = 1'b0;

`ifdef DFF_PIPE_OCC_EN
    logic [2:0] occ;
    logic [0:0] occ1;
`endif

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u_dut (
        .c       (clk),
        .r       (r),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .flush   (flush)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ     (occ)
`endif
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'h3C)) u_dut1 (
        .c       (clk),
        .r       (r),
        .d       (d1),
        .d_valid (d_valid1),
        .d_ready (d_ready1),
        .q       (q1),
        .q_valid (q_valid1),
        .q_ready (q_ready1),
        .flush   (flush1)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ     (occ1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        int acc;
        int exp_out;

        // ---------------- reset state
        #2 r = 1'b1;
        #1;
        chk("rst_qv", 32'(q_valid), 32'd0);
        chk("rst_q", 32'(q), 32'hA5);
        chk("rst_drdy", 32'(d_ready), 32'd1);
        chk("rst_q1", 32'(q1), 32'h3C);
        chk("rst_qv1", 32'(q_valid1), 32'd0);
`ifdef DFF_PIPE_OCC_EN
        chk("rst_occ", 32'(occ), 32'd0);
`endif
        tick();
        tick();
        r = 1'b0;

        // ---------------- stream, q_ready=1
        q_ready = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            d_valid = (n <= 16);
            d = 8'(n);
            tick();
            if (n <= 3) begin
                chk("str_qv_lat", 32'(q_valid), 32'd0);
                chk("str_q_lat", 32'(q), 32'hA5);
            end else if (n <= 19) begin
                chk("str_qv", 32'(q_valid), 32'd1);
                chk("str_q", 32'(q), 32'(n - 3));
            end else begin
                chk("str_qv_end", 32'(q_valid), 32'd0);
                chk("str_q_hold", 32'(q), 32'h10);
            end
        end
`ifdef DFF_PIPE_OCC_EN
        chk("str_occ", 32'(occ), 32'd0);
`endif

        // ---------------- backpressure
        q_ready = 1'b0;
        acc = 0;
        w = 1;
        for (int k = 0; k < 6; k++) begin
            d = 8'(w);
            d_valid = 1'b1;
            #1;
            chk("bp_rdy", 32'(d_ready), (acc < 4) ? 32'd1 : 32'd0);
            if (acc < 4) begin
                acc++;
                w++;
            end
            tick();
        end
        d = 8'(w);
        #1;
        chk("bp_full_rdy", 32'(d_ready), 32'd0);
        chk("bp_full_qv", 32'(q_valid), 32'd1);
        chk("bp_full_q", 32'(q), 32'h01);
`ifdef DFF_PIPE_OCC_EN
        chk("bp_occ", 32'(occ), 32'd4);
`endif
        q_ready = 1'b1;
        exp_out = 1;
        for (int k = 0; k < 12; k++) begin
            d_valid = (w <= 6);
            d = 8'(w);
            #1;
            if (k == 0) chk("bp_full_pass_rdy", 32'(d_ready), 32'd1);
            if (q_valid) begin
                chk("bp_out", 32'(q), 32'(exp_out));
                exp_out++;
            end
            if (d_valid && d_ready) w++;
            tick();
        end
        chk("bp_all_out", 32'(exp_out), 32'd7);
        chk("bp_all_in", 32'(w), 32'd7);
        chk("bp_empty", 32'(q_valid), 32'd0);

        // ---------------- bubble collapse
        q_ready = 1'b0;
        d = 8'h11; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        tick();
        tick();
        d = 8'h22; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("bub_qv", 32'(q_valid), 32'd1);
        chk("bub_q", 32'(q), 32'h11);
        chk("bub_drdy", 32'(d_ready), 32'd1);
`ifdef DFF_PIPE_OCC_EN
        chk("bub_occ", 32'(occ), 32'd2);
`endif
        q_ready = 1'b1;
        tick();
        chk("bub_q2", 32'(q), 32'h22);
        chk("bub_qv2", 32'(q_valid), 32'd1);
        tick();
        chk("bub_qv3", 32'(q_valid), 32'd0);

        // ---------------- flush
        q_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 8'(8'h31 + k); d_valid = 1'b1;
            tick();
        end
        d = 8'h35; d_valid = 1'b1; q_ready = 1'b1; flush = 1'b1;
        #1;
        chk("fl_drdy", 32'(d_ready), 32'd0);
        tick();
        flush = 1'b0; d_valid = 1'b0;
        #1;
        chk("fl_qv", 32'(q_valid), 32'd0);
        chk("fl_q_hold", 32'(q), 32'h31);
`ifdef DFF_PIPE_OCC_EN
        chk("fl_occ", 32'(occ), 32'd0);
`endif
        for (int k = 0; k < 5; k++) tick();
        chk("fl_no_in", 32'(q_valid), 32'd0);

        // ---------------- async reset with words held
        q_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 8'(8'h41 + k); d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        tick();
        chk("ar_pre_qv", 32'(q_valid), 32'd1);
        chk("ar_pre_q", 32'(q), 32'h41);
        r = 1'b1;
        #1;
        chk("ar_qv", 32'(q_valid), 32'd0);
        chk("ar_q", 32'(q), 32'hA5);
`ifdef DFF_PIPE_OCC_EN
        chk("ar_occ", 32'(occ), 32'd0);
`endif
        r = 1'b0;
        tick();
        chk("ar_after_qv", 32'(q_valid), 32'd0);

        // ---------------- DEPTH=1
        q_ready1 = 1'b1;
        d_valid1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d1 = 8'(8'h50 + k);
            tick();
            chk("d1_q", 32'(q1), 32'(8'h50 + k));
            chk("d1_qv", 32'(q_valid1), 32'd1);
        end
        q_ready1 = 1'b0;
        d1 = 8'h60;
        tick();
        chk("d1_full_q", 32'(q1), 32'h53);
        d1 = 8'h61;
        #1;
        chk("d1_full_rdy", 32'(d_ready1), 32'd0);
        q_ready1 = 1'b1;
        #1;
        chk("d1_pass_rdy", 32'(d_ready1), 32'd1);
        tick();
        chk("d1_replace_q", 32'(q1), 32'h61);
        chk("d1_replace_qv", 32'(q_valid1), 32'd1);
        d_valid1 = 1'b0;
        tick();
        chk("d1_empty", 32'(q_valid1), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
